// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer. It generates the pixel-tick enable, the x/y raster
// counters, the sync/blank/frame markers and a one-line-ahead fetch request
// stream with underrun detection. Starting and stopping only happen at frame
// boundaries.
//
// Handshake: fetch_req_o/fetch_line_o stay stable while fetch_req_o=1. A cycle
// with fetch_req_o=1 and fetch_ack_i=1 completes the request, and fetch_req_o
// drops in the following cycle. Ack while fetch_req_o=0 has no effect.
// A request that is still open on the tick entering x=0 of its line is
// dropped and latches underrun_o. An ack in that same cycle still counts as
// in time.
module vga_timing_ctrl #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk_sys_i,
    input  logic       reset_async_ni,
    input  logic       enable_i,
    input  logic       clear_underrun_i,
    output logic       pxl_tick_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       frame_start_o,
    output logic       running_o,
    output logic       fetch_req_o,
    output logic [9:0] fetch_line_o,
    input  logic       fetch_ack_i,
    output logic       underrun_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PW      = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_FETCH    = 10'(H_VISIBLE);
    // Range limits are 11 bits so that an end value of 1024 still compares correctly.
    localparam logic [10:0]   H_VIS_W    = 11'(H_VISIBLE);
    localparam logic [10:0]   V_VIS_W    = 11'(V_VISIBLE);
    localparam logic [10:0]   HS_BEG     = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0]   HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0]   VS_BEG     = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0]   VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [9:0]    fetch_line_q, fetch_line_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          visible_q, visible_d, frame_start_q, frame_start_d;
    logic          fetch_req_q, fetch_req_d, underrun_q, underrun_d;

    logic          tick, x_wrap, y_wrap, frame_wrap, deadline;
    logic [9:0]    x_nxt, y_nxt, next_line;

    // Raster helpers: pixel tick, counter successors and the line one ahead
    always_comb begin
        tick       = (state_q == S_RUN) && (presc_q == PRESC_LAST);
        x_wrap     = (x_q == H_LAST);
        y_wrap     = (y_q == V_LAST);
        frame_wrap = tick && x_wrap && y_wrap;
        x_nxt      = x_wrap ? 10'd0 : x_q + 10'd1;
        y_nxt      = !x_wrap ? y_q : (y_wrap ? 10'd0 : y_q + 10'd1);
        next_line  = y_wrap ? 10'd0 : y_q + 10'd1;
    end

    // FSM state register
    always_ff @(posedge clk_sys_i or negedge reset_async_ni) begin
        if (!reset_async_ni) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    // FSM next state: leave IDLE on enable, stop only at a frame wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (enable_i) state_d = S_RUN;
            S_RUN:      if (frame_wrap && !enable_i) state_d = S_STOPPING;
            S_STOPPING: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs: counters, timing outputs and fetch scheduling for the next cycle
    always_comb begin
        presc_d = '0;
        x_d     = '0;
        y_d     = '0;
        if (state_q == S_RUN && state_d == S_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            x_d     = tick ? x_nxt : x_q;
            y_d     = tick ? y_nxt : y_q;
        end

        visible_d = (state_d == S_RUN) && ({1'b0, x_d} < H_VIS_W) && ({1'b0, y_d} < V_VIS_W);
        hsync_d   = ((state_d == S_RUN) && ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END))
                    ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d   = ((state_d == S_RUN) && ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END))
                    ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_start_d = (state_d == S_RUN) && ((state_q == S_IDLE) || frame_wrap);

        // An open request that reaches the first pixel of its line is late
        deadline = tick && fetch_req_q && !fetch_ack_i &&
                   (x_nxt == 10'd0) && (y_nxt == fetch_line_q);

        fetch_req_d  = fetch_req_q && !fetch_ack_i && !deadline;
        fetch_line_d = fetch_line_q;
        // Entering the horizontal blanking starts the fetch of the next visible line
        if (tick && (x_nxt == H_FETCH) && ({1'b0, next_line} < V_VIS_W)) begin
            fetch_req_d  = 1'b1;
            fetch_line_d = next_line;
        end
        if (state_q == S_IDLE && state_d == S_RUN) begin
            fetch_req_d  = 1'b1;
            fetch_line_d = '0;
        end else if (state_d != S_RUN) begin
            fetch_req_d  = 1'b0;
            fetch_line_d = '0;
        end

        // A new underrun wins over a simultaneous clear
        underrun_d = (underrun_q && !clear_underrun_i) || deadline;
    end

    // Datapath registers
    always_ff @(posedge clk_sys_i or negedge reset_async_ni) begin
        if (!reset_async_ni) begin
            presc_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            visible_q     <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_req_q   <= 1'b0;
            fetch_line_q  <= '0;
            underrun_q    <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            frame_start_q <= frame_start_d;
            fetch_req_q   <= fetch_req_d;
            fetch_line_q  <= fetch_line_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pxl_tick_o    = tick;
    assign running_o     = (state_q != S_IDLE);
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign visible_o     = visible_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = frame_start_q;
    assign fetch_req_o   = fetch_req_q;
    assign fetch_line_o  = fetch_line_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a small raster. The reference model keeps
// one linear pixel index per frame and derives x/y, syncs and fetch deadlines
// from it arithmetically.
module tb_vga_timing_ctrl;

    localparam int DIV = 2;
    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clr = 1'b0;
    logic       ack = 1'b0;
    logic       pxl_tick, hsync, vsync, visible, frame_start, running, fetch_req, underrun;
    logic [9:0] x, y, fetch_line;

    // clock / reset
    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk_sys_i(clk), .reset_async_ni(rst_n), .enable_i(enable),
        .clear_underrun_i(clr), .pxl_tick_o(pxl_tick), .hsync_o(hsync),
        .vsync_o(vsync), .visible_o(visible), .x_o(x), .y_o(y),
        .frame_start_o(frame_start), .running_o(running), .fetch_req_o(fetch_req),
        .fetch_line_o(fetch_line), .fetch_ack_i(ack), .underrun_o(underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: mode 0 idle, 1 run, 2 stopping
    int         m_mode = 0;
    int         m_sub = 0;
    int         m_pix = 0;
    int         m_line = 0;
    logic       m_fs = 1'b0;
    logic       m_req = 1'b0;
    logic       m_ur = 1'b0;
    logic       rst_req = 1'b0;
    logic       prev_req = 1'b0;
    logic [9:0] exp_q[$];

    function automatic int m_x();
        return (m_mode == 1) ? m_pix % HT : 0;
    endfunction

    function automatic int m_y();
        return (m_mode == 1) ? m_pix / HT : 0;
    endfunction

    function automatic logic m_tick();
        return (m_mode == 1) && (m_sub == DIV - 1);
    endfunction

    function automatic logic [7:0] m_flags();
        int   mx = m_x();
        int   my = m_y();
        logic run = (m_mode == 1);
        logic hs = !(run && mx >= HV + HF && mx < HV + HF + HS);
        logic vs = !(run && my >= VV + VF && my < VV + VF + VS);
        logic vis = run && mx < HV && my < VV;
        return {m_tick(), hs, vs, vis, m_fs, (m_mode != 0), m_req, m_ur};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sub = 0; m_pix = 0; m_line = 0;
        m_fs = 1'b0; m_req = 1'b0; m_ur = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic cl, input logic ak);
        logic req_old = m_req;
        logic ur_new = 1'b0;
        int   npix, nx, ny;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (en) begin
                    m_mode = 1; m_sub = 0; m_pix = 0; m_fs = 1'b1; m_req = 1'b1; m_line = 0;
                end else begin
                    m_fs = 1'b0; m_req = 1'b0; m_line = 0;
                end
            end
            2: begin
                m_mode = 0; m_fs = 1'b0; m_req = 1'b0; m_line = 0;
            end
            default: begin
                m_fs = 1'b0;
                if (req_old && ak) m_req = 1'b0;
                if (m_sub == DIV - 1) begin
                    npix = (m_pix + 1) % FT;
                    nx = npix % HT;
                    ny = npix / HT;
                    if (req_old && !ak && nx == 0 && ny == m_line) begin
                        ur_new = 1'b1;
                        m_req = 1'b0;
                    end
                    if (nx == HV && ((ny + 1) % VT) < VV) begin
                        m_req = 1'b1;
                        m_line = (ny + 1) % VT;
                    end
                    m_sub = 0;
                    if (npix == 0 && !en) begin
                        m_mode = 2; m_req = 1'b0; m_line = 0; m_pix = 0;
                    end else begin
                        m_pix = npix;
                        if (npix == 0) m_fs = 1'b1;
                    end
                end else begin
                    m_sub++;
                end
            end
        endcase
        m_ur = (m_ur && !cl) || ur_new;
        if (!req_old && m_req) exp_q.push_back(10'(m_line));
    endtask

    // driver: compare at the falling edge, then apply this cycle's inputs
    // ack policy: 0 prompt, 1 never for line 2, 2 line 2 only on its deadline, 3 random, 4 none
    task automatic cycle(input logic en, input logic cl, input int pol);
        logic a;
        logic dl_now;
        @(negedge clk);
        check_eq("flags", 32'(m_flags()), 32'({pxl_tick, hsync, vsync, visible,
                                               frame_start, running, fetch_req, underrun}));
        check_eq("x", 32'(x), 32'(m_x()));
        check_eq("y", 32'(y), 32'(m_y()));
        check_eq("fetch_line", 32'(fetch_line), 32'(m_line));
        if (fetch_req && !prev_req) begin
            check_eq("fetch_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("fetch_seq", 32'(fetch_line), 32'(exp_q.pop_front()));
        end
        prev_req = fetch_req;
        rst_n = rst_req;
        dl_now = m_tick() && ((m_pix + 1) % FT == m_line * HT);
        case (pol)
            0: a = m_req;
            1: a = m_req && (m_line != 2);
            2: a = m_req && ((m_line != 2) || dl_now);
            3: a = ($urandom_range(0, 7) == 0);
            default: a = 1'b0;
        endcase
        enable = en;
        clr = cl;
        ack = a;
        model_step(en, cl, a);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_flags", 32'({pxl_tick, hsync, vsync, visible,
                                   frame_start, running, fetch_req, underrun}), 32'h60);
        check_eq("rst_x", 32'(x), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_line", 32'(fetch_line), 32'd0);
    endtask

    initial begin
        logic en_r;
        int   waited;
        // reset held, then idle with enable low
        repeat (3) cycle(1'b0, 1'b0, 0);
        check_reset_vals();
        rst_req = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 0);
        // two frames with prompt acks
        repeat (420) cycle(1'b1, 1'b0, 0);
        // line 2 never acked -> underrun, then clear it
        repeat (220) cycle(1'b1, 1'b0, 1);
        repeat (3) cycle(1'b1, 1'b1, 0);
        repeat (50) cycle(1'b1, 1'b0, 0);
        // line 2 acked exactly on its deadline tick
        repeat (220) cycle(1'b1, 1'b0, 2);
        // drop enable mid-frame: finish frame, STOPPING, IDLE
        repeat (250) cycle(1'b0, 1'b0, 0);
        // restart and leave the line-0 request open, then reset asynchronously
        waited = 0;
        cycle(1'b1, 1'b0, 4);
        while (!(m_req && m_mode == 1) && waited < 50) begin
            cycle(1'b1, 1'b0, 4);
            waited++;
        end
        check_eq("pending_before_reset", 32'(waited < 50), 32'd1);
        repeat (5) cycle(1'b1, 1'b0, 4);
        #1;
        rst_n = 1'b0;
        rst_req = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        exp_q.delete();
        prev_req = 1'b0;
        repeat (2) cycle(1'b1, 1'b0, 0);
        rst_req = 1'b1;
        repeat (100) cycle(1'b1, 1'b0, 0);
        // random segments of enable, clear and ack
        repeat (20) begin
            en_r = ($urandom_range(0, 3) != 0);
            repeat (100) cycle(en_r, ($urandom_range(0, 15) == 0), 3);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
